// File: rtl/mash_sdm_divctl.sv
// mash_sdm_divctl: MASH 1-1-1 fractional-N divide-ratio generator feeding the MMD DIVNUM input
// Ports: CKVD divided clock, NARST async active-low reset, EN modulator enable (low = integer-only),
//        LOAD shadow-word strobe, N_INT/N_FRAC requested ratio, DIVNUM registered ratio, SAT clamp flag.
// Optional feature: define SDM_DITHER_EN to add 15-bit LFSR dither on the stage-1 input.
module mash_sdm_divctl #(
    parameter int FRAC_W  = 16,
    parameter int OUT_W   = 9,
    parameter int ORDER   = 3,
    parameter int DIV_MIN = 4,
    parameter int DIV_RST = 32
) (
    input  logic              CKVD,
    input  logic              NARST,
    input  logic              EN,
    input  logic              LOAD,
    input  logic [OUT_W-1:0]  N_INT,
    input  logic [FRAC_W-1:0] N_FRAC,
    output logic [OUT_W-1:0]  DIVNUM,
    output logic              SAT
);
    localparam logic signed [OUT_W+1:0] MIN_S = (OUT_W+2)'(DIV_MIN);
    localparam logic signed [OUT_W+1:0] MAX_S = (OUT_W+2)'((1 << OUT_W) - 1);

    if (ORDER < 1 || ORDER > 3) begin : g_bad_order
        $error("mash_sdm_divctl: ORDER must be 1, 2 or 3");
    end

    logic [OUT_W-1:0]        int_sh_q, int_q, divnum_q, divnum_d;
    logic [FRAC_W-1:0]       frac_sh_q, frac_q, e1_q, e2_q, e3_q, e1_d, e2_d, e3_d;
    logic                    c2d_q, c3d_q, c3dd_q, sat_q, sat_d, c1, c2, c3, d;
    logic [FRAC_W:0]         s1, s2, s3;
    logic signed [3:0]       y;
    logic signed [OUT_W+1:0] sum;

`ifdef SDM_DITHER_EN
    logic [14:0] lfsr_q;
    assign d = lfsr_q[14];
    // x^15 + x^14 + 1; parked at its seed whenever the modulator is idle
    always_ff @(posedge CKVD or negedge NARST)
        if (!NARST) lfsr_q <= 15'h0001;
        else        lfsr_q <= EN ? {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]} : 15'h0001;
`else
    assign d = 1'b0;
`endif

    always_comb begin
        s1 = {1'b0, e1_q} + {1'b0, frac_q} + {{FRAC_W{1'b0}}, d};
        s2 = {1'b0, e2_q} + {1'b0, s1[FRAC_W-1:0]};
        s3 = {1'b0, e3_q} + {1'b0, s2[FRAC_W-1:0]};
        c1 = s1[FRAC_W];
        // stages above ORDER stay at zero and never carry
        c2 = ORDER >= 2 && s2[FRAC_W];
        c3 = ORDER >= 3 && s3[FRAC_W];
        e1_d = EN ? s1[FRAC_W-1:0] : '0;
        e2_d = EN && ORDER >= 2 ? s2[FRAC_W-1:0] : '0;
        e3_d = EN && ORDER >= 3 ? s3[FRAC_W-1:0] : '0;
        // noise cancellation: c1 + (1-z^-1)c2 + (1-z^-1)^2 c3
        y = EN ? $signed({3'b000, c1}) + $signed({3'b000, c2}) - $signed({3'b000, c2d_q})
               + $signed({3'b000, c3}) - $signed({2'b00, c3d_q, 1'b0}) + $signed({3'b000, c3dd_q})
               : 4'sd0;
        sum = $signed({2'b00, int_q}) + $signed({{(OUT_W-2){y[3]}}, y});
        sat_d = sum < MIN_S || sum > MAX_S;
        divnum_d = sum < MIN_S ? MIN_S[OUT_W-1:0] : sum > MAX_S ? MAX_S[OUT_W-1:0] : sum[OUT_W-1:0];
    end

    always_ff @(posedge CKVD or negedge NARST) begin
        if (!NARST) begin
            int_sh_q  <= OUT_W'(DIV_RST);
            int_q     <= OUT_W'(DIV_RST);
            frac_sh_q <= '0;
            frac_q    <= '0;
            e1_q      <= '0;
            e2_q      <= '0;
            e3_q      <= '0;
            c2d_q     <= 1'b0;
            c3d_q     <= 1'b0;
            c3dd_q    <= 1'b0;
            divnum_q  <= OUT_W'(DIV_RST);
            sat_q     <= 1'b0;
        end else begin
            if (LOAD) begin
                int_sh_q  <= N_INT;
                frac_sh_q <= N_FRAC;
            end
            // active word follows shadow one edge later, so a word change lands atomically
            int_q    <= int_sh_q;
            frac_q   <= frac_sh_q;
            e1_q     <= e1_d;
            e2_q     <= e2_d;
            e3_q     <= e3_d;
            c2d_q    <= EN && c2;
            c3d_q    <= EN && c3;
            c3dd_q   <= EN && c3d_q;
            divnum_q <= divnum_d;
            sat_q    <= sat_d;
        end
    end

    assign DIVNUM = divnum_q;
    assign SAT    = sat_q;
endmodule

// File: tb/tb_mash_sdm_divctl.sv
// tb_mash_sdm_divctl: scoreboard bench for the MASH divide-ratio generator (ORDER 3 and ORDER 1 instances)
module tb_mash_sdm_divctl;
    logic        CKVD = 1'b0;
    logic        NARST = 1'b1;
    logic        EN = 1'b0;
    logic        LOAD = 1'b0;
    logic [8:0]  N_INT = '0;
    logic [15:0] N_FRAC = '0;
    logic [8:0]  divnum3, divnum1;
    logic        sat3, sat1;
    int checks = 0;
    int failures = 0;

    typedef struct { logic [8:0] d3; logic s3; logic [8:0] d1; logic s1; } exp_t;
    exp_t sb[$];
    exp_t last_exp;
    int me1, me2, me3, mc2d, mc3d, mc3dd;
    int m_int, m_frac, m_int_sh, m_frac_sh;
    logic [8:0] ref_seq [20];
    longint acc;

    always #5 CKVD = ~CKVD;

    mash_sdm_divctl dut3 (.CKVD(CKVD), .NARST(NARST), .EN(EN), .LOAD(LOAD), .N_INT(N_INT),
                          .N_FRAC(N_FRAC), .DIVNUM(divnum3), .SAT(sat3));
    mash_sdm_divctl #(.ORDER(1)) dut1 (.CKVD(CKVD), .NARST(NARST), .EN(EN), .LOAD(LOAD), .N_INT(N_INT),
                          .N_FRAC(N_FRAC), .DIVNUM(divnum1), .SAT(sat1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] clampv(input int s);
        if (s < 4) return {1'b1, 9'd4};
        if (s > 511) return {1'b1, 9'd511};
        return {1'b0, 9'(s)};
    endfunction

    task automatic model_reset();
        me1 = 0; me2 = 0; me3 = 0; mc2d = 0; mc3d = 0; mc3dd = 0;
        m_int = 32; m_int_sh = 32; m_frac = 0; m_frac_sh = 0;
        sb.delete();
    endtask

    // predict this edge from current inputs, push, clock, then pop and compare
    task automatic step(input string tag);
        exp_t e;
        logic [9:0] r;
        int s1, s2, s3, c1, c2, c3, y3, y1;
        y3 = 0;
        y1 = 0;
        if (EN) begin
            s1 = me1 + m_frac;
            c1 = s1 / 65536;
            s1 = s1 % 65536;
            s2 = me2 + s1;
            c2 = s2 / 65536;
            s2 = s2 % 65536;
            s3 = me3 + s2;
            c3 = s3 / 65536;
            s3 = s3 % 65536;
            y3 = c1 + (c2 - mc2d) + (c3 - 2 * mc3d + mc3dd);
            y1 = c1;
            me1 = s1; me2 = s2; me3 = s3;
            mc3dd = mc3d; mc3d = c3; mc2d = c2;
        end else begin
            me1 = 0; me2 = 0; me3 = 0; mc2d = 0; mc3d = 0; mc3dd = 0;
        end
        r = clampv(m_int + y3);
        e.d3 = r[8:0];
        e.s3 = r[9];
        r = clampv(m_int + y1);
        e.d1 = r[8:0];
        e.s1 = r[9];
        m_int = m_int_sh;
        m_frac = m_frac_sh;
        if (LOAD) begin
            m_int_sh = int'(N_INT);
            m_frac_sh = int'(N_FRAC);
        end
        sb.push_back(e);
        @(posedge CKVD);
        #1;
        e = sb.pop_front();
        last_exp = e;
        chk({tag, ".d3"}, divnum3, e.d3);
        chk({tag, ".s3"}, sat3, e.s3);
        chk({tag, ".d1"}, divnum1, e.d1);
        chk({tag, ".s1"}, sat1, e.s1);
    endtask

    task automatic load_word(input int n, input int f);
        N_INT = 9'(n);
        N_FRAC = 16'(f);
        LOAD = 1'b1;
        step("load");
        LOAD = 1'b0;
        step("act");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 NARST = 1'b0;
        model_reset();
        #1;
        chk("rst_d3", divnum3, 32);
        chk("rst_s3", sat3, 0);
        chk("rst_d1", divnum1, 32);
        #1 NARST = 1'b1;
        for (int i = 0; i < 3; i++) step("idle");
        chk("idle_d3", divnum3, 32);

        // integer mode
        N_INT = 9'd40; N_FRAC = 16'h0000; LOAD = 1'b1; EN = 1'b1;
        step("int_load");
        LOAD = 1'b0;
        step("int_k1");
        chk("int_k1_old", divnum3, 32);
        for (int i = 0; i < 100; i++) begin
            step("int");
            chk("int40", divnum3, 40);
            chk("int_sat", sat3, 0);
        end

        // ORDER 1 alternation from zero state
        EN = 1'b0;
        load_word(20, 'h8000);
        EN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step("o1");
            chk("o1_seq", divnum1, (i % 2) ? 21 : 20);
        end

        // ORDER 3 full period: range and mean
        EN = 1'b0;
        load_word(50, 'h1234);
        EN = 1'b1;
        acc = 0;
        for (int i = 0; i < 65536; i++) begin
            step("o3");
            chk("o3_range", (divnum3 >= 9'd47 && divnum3 <= 9'd54), 1);
            acc += longint'(divnum3) - 50;
        end
        chk("o3_mean", (acc >= 'h1233 && acc <= 'h1236), 1);

        // high clamp: second cycle from zero state gives y=3
        EN = 1'b0;
        load_word(510, 'hFFFF);
        EN = 1'b1;
        step("hi0");
        chk("hi0_d3", divnum3, 510);
        step("hi1");
        chk("hi1_d3", divnum3, 511);
        chk("hi1_s3", sat3, 1);
        chk("hi1_d1", divnum1, 511);
        chk("hi1_s1", sat1, 0);
        for (int i = 0; i < 8; i++) step("hi");

        // low-end neighbourhood with full-scale fraction
        EN = 1'b0;
        load_word(5, 'hFFFF);
        EN = 1'b1;
        for (int i = 0; i < 32; i++) step("lo");

        // integer-only clamp boundaries
        EN = 1'b0;
        load_word(2, 0);
        step("lo2");
        chk("lo2_d3", divnum3, 4);
        chk("lo2_s3", sat3, 1);
        load_word(4, 0);
        step("lo4");
        chk("lo4_d3", divnum3, 4);
        chk("lo4_s3", sat3, 0);
        load_word(511, 0);
        step("top");
        chk("top_d3", divnum3, 511);
        chk("top_s3", sat3, 0);

        // EN toggle: gap shows the integer word, restart matches a fresh run
        load_word(60, 'h1234);
        EN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step("ref");
            ref_seq[i] = last_exp.d3;
        end
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("gap");
            chk("gap_d3", divnum3, 60);
            chk("gap_s3", sat3, 0);
        end
        EN = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step("re");
            chk("re_seq", divnum3, ref_seq[i]);
        end

        // asynchronous reset mid-run
        load_word(37, 0);
        step("pre");
        chk("pre_d3", divnum3, 37);
        #2 NARST = 1'b0;
        model_reset();
        #1;
        chk("arst_d3", divnum3, 32);
        chk("arst_s3", sat3, 0);
        chk("arst_d1", divnum1, 32);
        #1 NARST = 1'b1;
        EN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("post");
            chk("post_d3", divnum3, 32);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mash_sdm_divctl.md
Name: mash_sdm_divctl

Overview:
- Fractional-N divide-ratio generator: the writer side of the MMD divide-ratio interface.
- Clocked by the divided clock CKVD. Every CKVD period it produces a new DIVNUM for the multi-modulus divider.
- Uses a MASH 1-1-1 (order selectable) delta-sigma modulator, so the long-run average divide ratio equals N_INT + N_FRAC/2^FRAC_W.
- Sits between the PLL frequency-control register and the MMD.

Parameters:
- FRAC_W, 16: fractional word width and accumulator width.
- OUT_W, 9: DIVNUM width. Must match the MMD DIVNUM input.
- ORDER, 3: modulator order. Legal values are 1, 2 and 3; any other value is a compile-time error.
- DIV_MIN, 4: lower clamp for DIVNUM.
- DIV_RST, 32: reset value of the active integer word and of DIVNUM.

Ports:
- CKVD  input  1  divided clock; all state updates on its rising edge.
- NARST  input  1  reset; asynchronous, active-low.
- EN  input  1  modulator enable. When low, the block runs in integer-only mode.
- LOAD  input  1  strobe; captures N_INT/N_FRAC into the shadow registers.
- N_INT  input  OUT_W  integer divide ratio.
- N_FRAC  input  FRAC_W  fractional divide ratio, unsigned, LSB weight 2^-FRAC_W.
- DIVNUM  output  OUT_W  registered divide ratio to the MMD.
- SAT  output  1  registered; high when the current DIVNUM was clamped.

Behaviour:
- Reset (NARST low, async):
  - shadow and active integer words = DIV_RST; shadow and active fractional words = 0.
  - e1, e2, e3 = 0; carry delay taps c2d, c3d, c3dd = 0.
  - DIVNUM = DIV_RST; SAT = 0.
  - Reset mid-operation discards all state immediately; no partial word survives.
- Double-buffered word update:
  - LOAD high at edge k: shadow registers take N_INT/N_FRAC.
  - Edge k+1: active registers take shadow.
  - Edge k+2: first DIVNUM computed from the new word.
  - LOAD held high re-captures every edge. The last value wins, same 2-edge pipeline.
- Accumulator chain, combinational within one edge. F = active fractional word.
  - s1 = e1 + F (FRAC_W+1 bits); c1 = s1 MSB.
  - s2 = e2 + s1[FRAC_W-1:0]; c2 = s2 MSB.
  - s3 = e3 + s2[FRAC_W-1:0]; c3 = s3 MSB.
  - At the edge: e1, e2, e3 take the low FRAC_W bits of s1, s2, s3; c2d <= c2; c3d <= c3; c3dd <= c3d.
  - Stages above ORDER are held at 0 and contribute nothing.
- Noise-cancelled output, signed, 4 bits:
  - ORDER 1: y = c1 (range 0..1).
  - ORDER 2: y = c1 + c2 - c2d (range -1..2).
  - ORDER 3: y = c1 + c2 - c2d + c3 - 2*c3d + c3dd (range -3..4).
- Output arithmetic:
  - sum = active integer word (zero-extended to OUT_W+2 signed) + y.
  - If sum < DIV_MIN: DIVNUM = DIV_MIN, SAT = 1.
  - If sum > 2^OUT_W-1: DIVNUM = 2^OUT_W-1, SAT = 1.
  - Otherwise DIVNUM = sum, SAT = 0.
  - DIVNUM and SAT register on the same edge as the accumulators. DIVNUM is stable for the whole following CKVD period.
- EN low:
  - Accumulators and taps are synchronously cleared each edge.
  - y = 0; DIVNUM = clamp(active integer word).
  - The LOAD pipeline keeps operating.
  - On the first edge with EN high, computation starts from the zero state.
- F = 0 with EN high: y = 0 every cycle, so DIVNUM = N_INT exactly.
- Wrap-around: accumulators wrap modulo 2^FRAC_W; carry-out is the only overflow path.
- Mean property, unclamped: over any 2^FRAC_W consecutive cycles starting from zero state, sum(y) ∈ [N_FRAC-1, N_FRAC+2]. For ORDER 1 it is exactly N_FRAC.

Optional Feature:
- Macro: SDM_DITHER_EN.
- Defined:
  - A 15-bit LFSR (x^15+x^14+1), seeded to 15'h0001 on reset, advances each CKVD edge while EN is high.
  - Its output bit d is added to the stage-1 input: s1 = e1 + F + d.
  - The LFSR is cleared to its seed while EN is low.
  - Mean shift is +0.5 LSB of F.
- Not defined: d = 0, no LFSR logic present, behaviour exactly as above.

Test Plan:
- Reset: NARST low mid-run with DIVNUM=37 -> DIVNUM=32 and SAT=0 asynchronously; after release with EN=0, DIVNUM stays 32.
- Integer mode: LOAD N_INT=40, N_FRAC=0, EN=1 -> DIVNUM=40 from the 2nd edge after LOAD, constant for 100 cycles, SAT=0.
- ORDER=1, N_INT=20, N_FRAC=16'h8000 from zero state -> DIVNUM sequence 20,21,20,21,...
- ORDER=3, N_INT=50, N_FRAC=16'h1234, 65536 cycles -> every DIVNUM in 47..54; sum of (DIVNUM-50) within [0x1233, 0x1236].
- Clamp: N_INT=5, N_FRAC=16'hFFFF, ORDER=3 -> values below 4 appear as 4 with SAT=1; N_INT=510 -> values above 511 appear as 511 with SAT=1.
- EN toggle: EN dropped for 3 cycles mid-sequence -> DIVNUM = N_INT during the gap; after re-enable, the sequence matches a fresh run from zero state.
